// File: rtl/wts_bus_interface.sv
// Cartridge slot to internal bus bridge: synchronizes the slot strobes and turns each access into a clean bus cycle.
// Optional Z80 wait-state generation is built only when WTS_BUS_WAIT_EN is defined.
module wts_bus_interface #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        nreset,
  input  logic        clk,
  input  logic        slot_nsltsl,
  input  logic        slot_nrd,
  input  logic        slot_nwr,
  input  logic [15:0] slot_a,
  input  logic [7:0]  slot_d,
  output logic        bus_ce,
  output logic        bus_rd,
  output logic        bus_wr_req,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_wdata,
  output logic        slot_nwait
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RELEASE} state_t;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_wait_cycles
    $error("WAIT_CYCLES must be in 1..7");
  end

  // Order within the synchronizer vectors: {sel, rd, wr}, stored active-high.
  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic [1:0]  sync_ready_q;
  logic        s_sel;
  logic        s_rd;
  logic        s_wr;

  state_t      state_q;
  logic        bus_ce_q;
  logic        bus_rd_q;
  logic        bus_wr_req_q;
  logic [15:0] bus_address_q;
  logic [7:0]  bus_wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync_ready_q <= '0;
    end else begin
      sync1_q      <= ~{slot_nsltsl, slot_nrd, slot_nwr};
      sync2_q      <= sync1_q;
      sync_ready_q <= {sync_ready_q[0], 1'b1};
    end
  end

  assign {s_sel, s_rd, s_wr} = sync2_q;

`ifdef WTS_BUS_WAIT_EN
  localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);
  logic       slot_nwait_q;
  logic [2:0] wait_cnt_q;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= RELEASE;
      bus_ce_q      <= 1'b0;
      bus_rd_q      <= 1'b0;
      bus_wr_req_q  <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
`ifdef WTS_BUS_WAIT_EN
      slot_nwait_q  <= 1'b1;
      wait_cnt_q    <= '0;
`endif
    end else begin
      bus_wr_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_sel && s_wr) begin
            state_q       <= WRITE;
            bus_ce_q      <= 1'b1;
            bus_wr_req_q  <= 1'b1;
            bus_address_q <= slot_a;
            bus_wdata_q   <= slot_d;
          end else if (s_sel && s_rd) begin
            state_q       <= READ;
            bus_ce_q      <= 1'b1;
            bus_rd_q      <= 1'b1;
            bus_address_q <= slot_a;
`ifdef WTS_BUS_WAIT_EN
            slot_nwait_q  <= 1'b0;
            wait_cnt_q    <= 3'd1;
`endif
          end
        end
        READ: begin
          if (!s_rd || !s_sel) begin
            state_q      <= IDLE;
            bus_ce_q     <= 1'b0;
            bus_rd_q     <= 1'b0;
`ifdef WTS_BUS_WAIT_EN
            slot_nwait_q <= 1'b1;
            wait_cnt_q   <= '0;
`endif
          end
`ifdef WTS_BUS_WAIT_EN
          else if (wait_cnt_q == WAIT_CNT) begin
            slot_nwait_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
`endif
        end
        WRITE: begin
          if (!s_wr || !s_sel) begin
            state_q  <= IDLE;
            bus_ce_q <= 1'b0;
          end
        end
        RELEASE: begin
          // Wait until the synchronizers hold real samples, otherwise a strobe
          // still low across reset would look idle for two cycles.
          if (sync_ready_q[1] && !s_sel && !s_rd && !s_wr) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= RELEASE;
      endcase
    end
  end

  assign bus_ce      = bus_ce_q;
  assign bus_rd      = bus_rd_q;
  assign bus_wr_req  = bus_wr_req_q;
  assign bus_address = bus_address_q;
  assign bus_wdata   = bus_wdata_q;
`ifdef WTS_BUS_WAIT_EN
  assign slot_nwait  = slot_nwait_q;
`else
  assign slot_nwait  = 1'b1;
`endif

endmodule

// File: tb/tb_wts_bus_interface.sv
// Self-checking bench for wts_bus_interface: scenario tasks drive slot accesses, a queue holds the expected bus transactions.
module tb_wts_bus_interface;

  logic        nreset;
  logic        clk;
  logic        slot_nsltsl;
  logic        slot_nrd;
  logic        slot_nwr;
  logic [15:0] slot_a;
  logic [7:0]  slot_d;
  logic        bus_ce;
  logic        bus_rd;
  logic        bus_wr_req;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic        slot_nwait;

  wts_bus_interface #(.WAIT_CYCLES(4)) dut (
    .nreset      (nreset),
    .clk         (clk),
    .slot_nsltsl (slot_nsltsl),
    .slot_nrd    (slot_nrd),
    .slot_nwr    (slot_nwr),
    .slot_a      (slot_a),
    .slot_d      (slot_d),
    .bus_ce      (bus_ce),
    .bus_rd      (bus_rd),
    .bus_wr_req  (bus_wr_req),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .slot_nwait  (slot_nwait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_addr;
  logic [7:0]  last_data;

  // Per-access statistics, indexed by clock edges after the strobe fall.
  int   wr_n, wr_at, ce_n, rd_n, nw_n, nw_at, ce_drop;
  logic rd_prev;

  task automatic sample(input int i, input bit in_strobe);
    exp_t e;
    if (bus_wr_req) begin
      wr_n++;
      if (wr_at < 0) wr_at = i;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_write: got addr=%h data=%h, want no write", bus_address, bus_wdata);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_wr || bus_address !== e.addr || bus_wdata !== e.data) begin
          bad++;
          $display("FAIL sb_write: got wr addr=%h data=%h, want wr=%0b addr=%h data=%h",
                   bus_address, bus_wdata, e.is_wr, e.addr, e.data);
        end
      end
    end
    if (bus_rd && !rd_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_read: got addr=%h, want no read", bus_address);
      end else begin
        e = exp_q.pop_front();
        if (e.is_wr || bus_address !== e.addr) begin
          bad++;
          $display("FAIL sb_read: got rd addr=%h, want wr=%0b addr=%h", bus_address, e.is_wr, e.addr);
        end
      end
    end
    rd_prev = bus_rd;
    if (in_strobe) begin
      if (bus_ce) ce_n++;
      if (bus_rd) rd_n++;
      if (!slot_nwait) begin
        nw_n++;
        if (nw_at < 0) nw_at = i;
      end
    end else if (!bus_ce && ce_drop < 0) begin
      ce_drop = i;
    end
  endtask

  // sel_delay: 0 selects together with the strobe, N>0 selects N cycles later, -1 never selects.
  task automatic access(input bit do_rd, input bit do_wr, input int sel_delay,
                        input logic [15:0] a, input logic [7:0] d, input int len);
    wr_n = 0; wr_at = -1; ce_n = 0; rd_n = 0; nw_n = 0; nw_at = -1; ce_drop = -1; rd_prev = 1'b0;
    @(negedge clk);
    slot_a      = a;
    slot_d      = d;
    slot_nrd    = !do_rd;
    slot_nwr    = !do_wr;
    slot_nsltsl = (sel_delay == 0) ? 1'b0 : 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      sample(i, 1'b1);
      if (i == sel_delay) slot_nsltsl = 1'b0;
    end
    slot_nrd    = 1'b1;
    slot_nwr    = 1'b1;
    slot_nsltsl = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      sample(i, 1'b0);
    end
  endtask

  task automatic push_exp(input logic is_wr, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
    last_addr = a;
    if (is_wr) last_data = d;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    slot_nsltsl = 1'b1; slot_nrd = 1'b1; slot_nwr = 1'b1;
    slot_a = 16'hFFFF; slot_d = 8'hFF;
    #12;
    total++;
    if ({bus_ce, bus_rd, bus_wr_req, slot_nwait} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ctrl: got ce/rd/wr/nwait=%b, want 0001", {bus_ce, bus_rd, bus_wr_req, slot_nwait});
    end
    total++;
    if (bus_address !== 16'h0000 || bus_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got addr=%h data=%h, want 0000 00", bus_address, bus_wdata);
    end
    last_addr = 16'h0000;
    last_data = 8'h00;
    @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    push_exp(1'b1, 16'h9000, 8'h3F);
    access(1'b0, 1'b1, 0, 16'h9000, 8'h3F, 10);
    total++;
    if (wr_n !== 1 || wr_at !== 3) begin
      bad++;
      $display("FAIL write_pulse: got count=%0d edge=%0d, want count=1 edge=3", wr_n, wr_at);
    end
    total++;
    if (ce_n !== 8 || rd_n !== 0) begin
      bad++;
      $display("FAIL write_ce: got ce_cycles=%0d rd_cycles=%0d, want 8 0", ce_n, rd_n);
    end
    total++;
    if (ce_drop < 2 || ce_drop > 3) begin
      bad++;
      $display("FAIL write_ce_drop: got edge %0d after rise, want 2..3", ce_drop);
    end
    total++;
    if (bus_address !== 16'h9000 || bus_wdata !== 8'h3F) begin
      bad++;
      $display("FAIL write_hold: got addr=%h data=%h, want 9000 3f", bus_address, bus_wdata);
    end
  endtask

  task automatic test_read;
    push_exp(1'b0, 16'h4123, 8'h00);
    access(1'b1, 1'b0, 0, 16'h4123, 8'h00, 10);
    total++;
    if (rd_n !== 8 || ce_n !== 8 || wr_n !== 0) begin
      bad++;
      $display("FAIL read_ctrl: got rd=%0d ce=%0d wr=%0d, want 8 8 0", rd_n, ce_n, wr_n);
    end
    total++;
`ifdef WTS_BUS_WAIT_EN
    if (nw_n !== 4 || nw_at !== 3) begin
      bad++;
      $display("FAIL read_nwait: got low=%0d from edge %0d, want low=4 from edge 3", nw_n, nw_at);
    end
`else
    if (nw_n !== 0) begin
      bad++;
      $display("FAIL read_nwait: got low=%0d cycles, want 0", nw_n);
    end
`endif
    total++;
    if (bus_address !== 16'h4123 || bus_wdata !== last_data) begin
      bad++;
      $display("FAIL read_hold: got addr=%h data=%h, want 4123 %h", bus_address, bus_wdata, last_data);
    end
  endtask

  task automatic test_write_priority;
    push_exp(1'b1, 16'hB000, 8'h80);
    access(1'b1, 1'b1, 0, 16'hB000, 8'h80, 8);
    total++;
    if (wr_n !== 1 || rd_n !== 0 || ce_n !== 6) begin
      bad++;
      $display("FAIL priority: got wr=%0d rd=%0d ce=%0d, want 1 0 6", wr_n, rd_n, ce_n);
    end
  endtask

  task automatic test_no_select;
    access(1'b0, 1'b1, -1, 16'h1234, 8'h55, 10);
    total++;
    if (wr_n !== 0 || ce_n !== 0 || rd_n !== 0 || nw_n !== 0) begin
      bad++;
      $display("FAIL no_select: got wr=%0d ce=%0d rd=%0d nwait_low=%0d, want all 0", wr_n, ce_n, rd_n, nw_n);
    end
    total++;
    if (bus_address !== last_addr || bus_wdata !== last_data) begin
      bad++;
      $display("FAIL no_select_hold: got addr=%h data=%h, want %h %h", bus_address, bus_wdata, last_addr, last_data);
    end
  endtask

  task automatic test_late_select;
    push_exp(1'b1, 16'h7FFE, 8'hA5);
    access(1'b0, 1'b1, 4, 16'h7FFE, 8'hA5, 10);
    total++;
    if (wr_n !== 1 || wr_at !== 7) begin
      bad++;
      $display("FAIL late_select: got count=%0d edge=%0d, want count=1 edge=7", wr_n, wr_at);
    end
  endtask

  task automatic test_reset_mid_access;
    int bus_hits;
    bus_hits = 0;
    @(negedge clk);
    slot_a = 16'hC000; slot_d = 8'h11;
    slot_nsltsl = 1'b0; slot_nwr = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    #1;
    total++;
    if (bus_ce !== 1'b0 || bus_wr_req !== 1'b0 || bus_address !== 16'h0000) begin
      bad++;
      $display("FAIL abort_reset: got ce=%b wr=%b addr=%h, want 0 0 0000", bus_ce, bus_wr_req, bus_address);
    end
    last_addr = 16'h0000;
    last_data = 8'h00;
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_ce || bus_wr_req) bus_hits++;
    end
    total++;
    if (bus_hits !== 0) begin
      bad++;
      $display("FAIL abort_ignore: got %0d active cycles, want 0", bus_hits);
    end
    slot_nsltsl = 1'b1; slot_nwr = 1'b1;
    repeat (5) @(negedge clk);
    push_exp(1'b1, 16'hC001, 8'h22);
    access(1'b0, 1'b1, 0, 16'hC001, 8'h22, 6);
    total++;
    if (wr_n !== 1 || wr_at !== 3) begin
      bad++;
      $display("FAIL abort_recover: got count=%0d edge=%0d, want count=1 edge=3", wr_n, wr_at);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic [7:0]  d;
    bit          rd;
    int          len;
    for (int k = 0; k < 6; k++) begin
      a   = 16'($urandom);
      d   = 8'($urandom);
      rd  = (k % 3 == 2);
      len = $urandom_range(4, 8);
      push_exp(!rd, a, d);
      access(rd, !rd, 0, a, d, len);
      total++;
      if (rd ? (rd_n !== len - 2 || wr_n !== 0) : (wr_n !== 1 || wr_at !== 3)) begin
        bad++;
        $display("FAIL b2b_%0d: got wr=%0d at %0d rd=%0d, want rd=%0b len=%0d", k, wr_n, wr_at, rd_n, rd, len);
      end
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_write_priority;
    test_no_select;
    test_late_select;
    test_reset_mid_access;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wts_bus_interface.md
WTS_BUS_INTERFACE -- requirements
Module: wts_bus_interface

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, range 1..7: number of clk cycles slot_nwait is held low per read; used only when WTS_BUS_WAIT_EN is defined.
REQ-002 nreset  input  1  asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 slot_nsltsl  input  1  cartridge slot select, active-low, asynchronous to clk.
REQ-005 slot_nrd  input  1  read strobe, active-low, asynchronous.
REQ-006 slot_nwr  input  1  write strobe, active-low, asynchronous.
REQ-007 slot_a  input  16  slot address, stable for the whole strobe.
REQ-008 slot_d  input  8  slot write data, stable for the whole write strobe.
REQ-009 bus_ce  output  1  access in progress; feeds the bank/SRAM controller chip enable.
REQ-010 bus_rd  output  1  current access is a read.
REQ-011 bus_wr_req  output  1  single-cycle write pulse.
REQ-012 bus_address  output  16  latched access address.
REQ-013 bus_wdata  output  8  latched write data.
REQ-014 slot_nwait  output  1  Z80 wait request, active-low.

Function
REQ-015 The block SHALL pass slot_nsltsl, slot_nrd and slot_nwr each through a 2-flop synchronizer; all decisions use the synchronized copies (s_sel, s_rd, s_wr, active-high after inversion).
REQ-016 The FSM SHALL have the states IDLE, READ, WRITE and RELEASE.
REQ-017 IDLE: if s_sel & s_wr, go to WRITE and latch slot_a->bus_address and slot_d->bus_wdata in the same edge; else if s_sel & s_rd, go to READ and latch slot_a only.
REQ-018 If s_rd and s_wr are both active in IDLE, the access SHALL be treated as a write (write priority).
REQ-019 bus_wr_req SHALL be 1 for exactly the first cycle in WRITE, so a strobe fall gives the pulse on the 3rd clk edge (2 sync + 1 FSM), once per strobe regardless of its length.
REQ-020 READ and WRITE SHALL return to IDLE on the first cycle in which the state's own strobe or s_sel is inactive.
REQ-021 bus_ce SHALL be 1 in READ and WRITE and 0 in IDLE and RELEASE; bus_rd SHALL be 1 only in READ.
REQ-022 bus_address and bus_wdata SHALL hold their values outside capture edges.
REQ-023 RELEASE SHALL remain active until s_rd, s_wr and s_sel are all inactive, then go to IDLE; no access is started from RELEASE.
REQ-024 A strobe that begins while s_sel is inactive and where s_sel is asserted later SHALL start an access at the first cycle both are active.

Reset
REQ-025 While nreset=0: state=RELEASE, bus_ce=0, bus_rd=0, bus_wr_req=0, bus_address=0, bus_wdata=0, slot_nwait=1, wait counter=0, synchronizers=inactive.
REQ-026 Reset asserted mid-access SHALL abort the access immediately with no bus_wr_req; after release, a strobe still low SHALL be ignored (RELEASE) until it deasserts.

Configuration
REQ-027 With WTS_BUS_WAIT_EN defined: on entry to READ, slot_nwait SHALL go 0 and a 3-bit counter SHALL run; slot_nwait returns to 1 after WAIT_CYCLES clk cycles or on leaving READ, whichever comes first.
REQ-028 Without WTS_BUS_WAIT_EN: slot_nwait SHALL be constant 1; the counter is not built; all other behaviour is identical.

Verification
REQ-029 Write 0x3F to slot_a=0x9000 with a 10-clk strobe -> exactly one bus_wr_req on the 3rd edge after nwr fall, bus_address=0x9000, bus_wdata=0x3F, bus_ce=1 until 2-3 clks after nwr rise.
REQ-030 Read from slot_a=0x4123 -> bus_rd=1, bus_ce=1, bus_address=0x4123 for the strobe duration; bus_wr_req stays 0.
REQ-031 nrd and nwr low together with slot_a=0xB000 and slot_d=0x80 -> write path taken, bus_rd=0, one bus_wr_req.
REQ-032 nreset pulse while nwr is low, strobe kept low 20 clk after release -> no bus_wr_req and bus_ce=0 until the strobe rises; the next write is handled normally.
REQ-033 With WTS_BUS_WAIT_EN and WAIT_CYCLES=4, read -> slot_nwait low for exactly 4 clk starting at READ entry; without the macro -> slot_nwait=1 throughout.
REQ-034 Write with nsltsl held high -> no state change and all outputs remain at their idle values.
